// File: rtl/neuron_controller_if.sv
// rtl/neuron_controller_if.sv - host, MAC and input-memory handshake bundle for neuron_controller.
// Optional keep_thr signal exists only when NEURON_CTRL_THR_REUSE_EN is defined.
interface neuron_controller_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic                  abort;
  logic                  thr_valid;
  logic                  thr_ack;
  logic                  thr_err;
  logic                  threshold_ready;
  logic                  data_valid;
  logic                  mac_clear;
  logic                  mac_en;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  act_bit;
  logic                  busy;
  logic                  result_valid;
  logic                  result;
`ifdef NEURON_CTRL_THR_REUSE_EN
  logic                  keep_thr;
`endif

  modport master (
`ifdef NEURON_CTRL_THR_REUSE_EN
    input  keep_thr,
`endif
    input  start, abort, thr_valid, data_valid, act_bit,
    output thr_ack, thr_err, threshold_ready, mac_clear, mac_en, in_addr,
    output busy, result_valid, result
  );

  modport slave (
`ifdef NEURON_CTRL_THR_REUSE_EN
    output keep_thr,
`endif
    output start, abort, thr_valid, data_valid, act_bit,
    input  thr_ack, thr_err, threshold_ready, mac_clear, mac_en, in_addr,
    input  busy, result_valid, result
  );
endinterface

// File: rtl/neuron_controller.sv
// rtl/neuron_controller.sv - sequencer for one neuron evaluation: threshold load, MAC stream, drain, compare.
// Defining NEURON_CTRL_THR_REUSE_EN adds keep_thr, letting start skip the threshold load.
module neuron_controller #(
  parameter int WIDTH       = 22,
  parameter int BUS_WIDTH   = 16,
  parameter int NUM_INPUTS  = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int MAC_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  neuron_controller_if.master   bus
);

  localparam int THR_BEATS = (WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int DRAIN_W   = $clog2(MAC_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [DRAIN_W-1:0]    LAST_DRAIN = DRAIN_W'(MAC_LATENCY - 1);

  if (THR_BEATS != 2 || NUM_INPUTS < 1 || MAC_LATENCY < 1 ||
      (2 ** ADDR_WIDTH) < NUM_INPUTS) begin : g_bad_params
    $error("neuron_controller: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_THR_LO, S_THR_HI, S_CLEAR, S_ACCUM, S_DRAIN, S_COMPARE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DRAIN_W-1:0]    r_drain;
  logic                  r_busy;
  logic                  r_thr_err;
  logic                  r_mac_clear;
  logic                  r_result_valid;
  logic                  r_result;
  logic                  w_keep;
  logic                  w_thr_phase;

`ifdef NEURON_CTRL_THR_REUSE_EN
  assign w_keep = bus.keep_thr;
`else
  assign w_keep = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_drain        <= '0;
      r_busy         <= 1'b0;
      r_thr_err      <= 1'b0;
      r_mac_clear    <= 1'b0;
      r_result_valid <= 1'b0;
      r_result       <= 1'b0;
    end else begin
      r_thr_err      <= 1'b0;
      r_mac_clear    <= 1'b0;
      r_result_valid <= 1'b0;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_busy <= 1'b1;
              if (w_keep) begin
                r_state     <= S_CLEAR;
                r_mac_clear <= 1'b1;
                r_cnt       <= '0;
              end else begin
                r_state <= S_THR_LO;
              end
            end
          end
          S_THR_LO: begin
            if (bus.thr_valid) r_state <= S_THR_HI;
          end
          S_THR_HI: begin
            // The high beat must follow the low beat with no gap.
            if (bus.thr_valid) begin
              r_state     <= S_CLEAR;
              r_mac_clear <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_thr_err <= 1'b1;
            end
          end
          S_CLEAR: begin
            r_state <= S_ACCUM;
          end
          S_ACCUM: begin
            if (bus.data_valid) begin
              if (r_cnt == LAST_ADDR) begin
                r_state <= S_DRAIN;
                r_drain <= '0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (r_drain == LAST_DRAIN) r_state <= S_COMPARE;
            else                       r_drain <= r_drain + 1'b1;
          end
          S_COMPARE: begin
            r_result       <= bus.act_bit;
            r_result_valid <= 1'b1;
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Same-cycle strobes are masked by abort so a cancelled cycle never accepts a beat.
  assign w_thr_phase         = (r_state == S_THR_LO) || (r_state == S_THR_HI);
  assign bus.threshold_ready = w_thr_phase & bus.thr_valid & ~bus.abort;
  assign bus.thr_ack         = w_thr_phase & bus.thr_valid & ~bus.abort;
  assign bus.mac_en          = (r_state == S_ACCUM) & bus.data_valid & ~bus.abort;
  assign bus.mac_clear       = r_mac_clear & ~bus.abort;
  assign bus.in_addr         = r_cnt;
  assign bus.thr_err         = r_thr_err;
  assign bus.busy            = r_busy;
  assign bus.result_valid    = r_result_valid;
  assign bus.result          = r_result;

endmodule

// File: doc/neuron_controller.md
# neuron_controller

Sequencer for one neuron evaluation on the MAC and threshold-activation datapath. It runs a two-beat threshold load over the 16-bit input bus, then clears the MAC and streams NUM_INPUTS input/weight addresses into it. After waiting for the MAC pipeline to drain, it samples the activation comparator bit and returns it as a one-cycle result. It sits between the host/layer scheduler and the MAC, activation-function and input/weight memory.

## Interface
- WIDTH, 22, MAC output / threshold width (passed through for consistency; threshold spans two beats).
- BUS_WIDTH, 16, input bus width; threshold beat width.
- NUM_INPUTS, 16, MAC operations per evaluation (≥1).
- ADDR_WIDTH, 4, width of in_addr; 2^ADDR_WIDTH ≥ NUM_INPUTS.
- MAC_LATENCY, 2, cycles from the last mac_en until act_bit reflects the final sum (≥1).

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin evaluation; sampled only in IDLE
- abort  in  1  cancel evaluation; highest priority
- thr_valid  in  1  host presents a threshold beat on the input bus
- thr_ack  out  1  beat accepted this cycle
- thr_err  out  1  one-cycle pulse; high beat missing
- threshold_ready  out  1  load enable to the activation function
- data_valid  in  1  input/weight memory data valid for in_addr
- mac_clear  out  1  clear MAC accumulator
- mac_en  out  1  MAC accumulate enable
- in_addr  out  ADDR_WIDTH  input/weight memory address
- act_bit  in  1  activation comparator output
- busy  out  1  evaluation in progress
- result_valid  out  1  one-cycle pulse
- result  out  1  captured activation bit

## Operation
- States: IDLE, THR_LO, THR_HI, CLEAR, ACCUM, DRAIN, COMPARE.
- IDLE: start=1 -> THR_LO.
- THR_LO: wait for thr_valid. With thr_valid=1: threshold_ready=1, thr_ack=1, -> THR_HI.
- THR_HI: the high beat must arrive in the next consecutive cycle.
  - thr_valid=1: threshold_ready=1, thr_ack=1, -> CLEAR.
  - thr_valid=0: threshold_ready=0, thr_err pulses next cycle, -> IDLE, no result.
- threshold_ready is combinational from state and thr_valid. It is never high outside THR_LO/THR_HI and never for more than 2 consecutive cycles.
- CLEAR: mac_clear=1 for exactly one cycle; address counter cleared to 0; -> ACCUM.
- ACCUM: mac_en = data_valid; in_addr = counter.
  - Counter increments only on data_valid=1.
  - data_valid=0: hold in_addr, mac_en=0.
  - The accepted beat at counter NUM_INPUTS-1 -> DRAIN.
- DRAIN: MAC_LATENCY cycles, mac_en=0; -> COMPARE.
- COMPARE: sample act_bit into result; result_valid=1 on the next cycle; -> IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- abort=1 in any state -> IDLE on the next edge. Deasserts all strobes; no result_valid, no thr_err; result is unchanged.
- abort and start in the same IDLE cycle: abort wins, stay IDLE.

## Timing
- Reset values: state IDLE, counter 0, and all outputs 0 (thr_ack, thr_err, threshold_ready, mac_clear, mac_en, in_addr, busy, result_valid, result).
- Cycle 0 = start high in IDLE. With thr_valid and data_valid held high, NUM_INPUTS=16, MAC_LATENCY=2:
  - cycle 1: THR_LO
  - cycle 2: THR_HI
  - cycle 3: CLEAR
  - cycles 4–19: ACCUM, in_addr 0..15
  - cycles 20–21: DRAIN
  - cycle 22: COMPARE
  - cycle 23: result_valid=1, busy=0
- General minimum latency: NUM_INPUTS+MAC_LATENCY+5 cycles. Each data_valid=0 cycle in ACCUM adds 1; each idle cycle in THR_LO adds 1.
- A start in the result_valid cycle is accepted (back-to-back evaluations).
- in_addr never exceeds NUM_INPUTS-1 and returns to 0 in CLEAR.

## Configuration
- NEURON_CTRL_THR_REUSE_EN defined: adds input keep_thr (1 bit).
  - start with keep_thr=1 goes IDLE -> CLEAR directly; the previously loaded threshold is reused.
  - Minimum latency drops by 2.
  - keep_thr=1 before any threshold load since reset is permitted; the activation function's threshold register then holds whatever value it contains.
- Not defined: no keep_thr port; every evaluation loads the threshold.

## Test plan
- Nominal: start, thr_valid held, data_valid held, act_bit=1 from cycle 20 -> threshold_ready high cycles 1–2 only, mac_clear cycle 3, in_addr 0..15 cycles 4–19, result_valid=1 and result=1 at cycle 23.
- Beat gap: thr_valid high cycle 1, low cycle 2 -> thr_err pulse cycle 3, busy=0 cycle 3, no mac_clear, no result_valid.
- Memory stall: data_valid low on cycles 6 and 10 -> in_addr holds 2 and 5 across the stalls, exactly 16 mac_en pulses, result_valid at cycle 25.
- Abort mid-ACCUM at in_addr=7 with prior result=1 -> IDLE next cycle, mac_en=0, result stays 1, no result_valid; a following start completes normally.
- Reset mid-THR_HI: rst asserted asynchronously -> all outputs 0 immediately; start ignored while rst high.
- With NEURON_CTRL_THR_REUSE_EN: load once, then start with keep_thr=1 -> no threshold_ready, mac_clear in cycle 1, result_valid at cycle 21.
